axo_sim_console: RTL and testbench

Memory-mapped console and run-control peripheral for the bootsim and later multi-core sim tops. It sits on the CPU data bus next to the RAM and decodes a small register window. It buffers characters from up to four channels in per-channel FIFOs and drains them round-robin to a byte sink with backpressure. It also provides exit-code/done reporting, a free-running cycle counter and a watchdog timeout, replacing ad-hoc "write to address 255" printing.

---
 rtl/axo_sim_console_pkg.sv | 48 ++++
 rtl/axo_sync_fifo.sv | 72 +++++++
 rtl/axo_sim_console.sv | 206 ++++++++++++++++++++
 tb/tb_axo_sim_console.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axo_sim_console_pkg.sv
// axo_sim_console_pkg
//   Shared constants for the console/run-control peripheral: register byte
//   offsets inside the 32-byte window, STATUS bit positions, the exit code
//   reported on watchdog expiry, and a helper that classifies a window offset.
package axo_sim_console_pkg;

  localparam logic [4:0] OFF_TXDATA = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h10;
  localparam logic [4:0] OFF_EXIT   = 5'h14;
  localparam logic [4:0] OFF_CYCLE  = 5'h18;

  localparam int STAT_FULL_LSB  = 0;
  localparam int STAT_EMPTY_LSB = 4;
  localparam int STAT_DONE_BIT  = 8;

  localparam logic [7:0] EXIT_CODE_TIMEOUT = 8'hFF;

  // Hardware slots always present; slots >= CHANNELS are tied off as empty.
  localparam int MAX_CHANNELS = 4;

  typedef enum logic [2:0] {
    SEL_TX,
    SEL_STATUS,
    SEL_EXIT,
    SEL_CYCLE,
    SEL_NONE
  } reg_sel_e;

  // Byte lanes within a word are ignored; registers are word-addressed.
  function automatic reg_sel_e decode_sel(input logic [4:0] off);
    logic [4:0] word_off;
    reg_sel_e   sel;
    word_off = {off[4:2], 2'b00};
    sel      = SEL_NONE;
    if (word_off[4] == OFF_TXDATA[4]) begin
      sel = SEL_TX;
    end else begin
      case (word_off)
        OFF_STATUS: sel = SEL_STATUS;
        OFF_EXIT:   sel = SEL_EXIT;
        OFF_CYCLE:  sel = SEL_CYCLE;
        default:    sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/axo_sync_fifo.sv
// axo_sync_fifo
//   Single-clock FIFO with registered full/empty/level and a combinational
//   read port showing the head entry.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wdata     enqueue (ignored when full)
//   pop, rdata      dequeue (ignored when empty); rdata is the current head
//   full, empty     registered status
//   level           number of entries held (0..DEPTH)
module axo_sync_fifo
  import axo_sim_console_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/axo_sim_console.sv
// axo_sim_console
//   Memory-mapped console and run-control peripheral. Decodes a 32-byte
//   window at BASE_ADDR, queues TX characters per channel, drains them
//   round-robin into a single output byte register, and tracks run
//   completion (EXIT write or watchdog) plus a free-running cycle counter.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mem_re/we/asize/addr/wdata   CPU data bus request
//   mem_rdata, mem_hit, mem_ready  combinational bus response
//   out_valid/chan/data, out_ready  byte sink with backpressure
//   done, exit_code, timed_out   run status
module axo_sim_console
  import axo_sim_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int          CHANNELS   = 1,
  parameter int          FIFO_DEPTH = 16,
  parameter int          TIMEOUT    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [1:0]  mem_asize,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_hit,
  output logic        mem_ready,
  output logic        out_valid,
  output logic [1:0]  out_chan,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        done,
  output logic [7:0]  exit_code,
  output logic        timed_out
);

  localparam int          LW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]  NCH          = 3'(CHANNELS);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  logic [MAX_CHANNELS-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0]              fifo_rdata [MAX_CHANNELS];
  logic [LW-1:0]           fifo_level [MAX_CHANNELS];

  reg_sel_e    sel;
  logic        hit, tx_wr, stall, exit_wr, timeout_now, load, gnt_found;
  logic [1:0]  tx_chan, gnt_chan;
  logic [2:0]  cand;

  logic [31:0] cycle_q, cycle_d;
  logic        done_q, done_d;
  logic        timed_out_q, timed_out_d;
  logic [7:0]  exit_code_q, exit_code_d;
  logic        out_valid_q, out_valid_d;
  logic [1:0]  out_chan_q, out_chan_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [1:0]  rr_q, rr_d;

  logic unused_inputs;
  assign unused_inputs = ^{mem_asize, mem_wdata[31:8]};

  for (genvar c = 0; c < MAX_CHANNELS; c++) begin : g_chan
    if (c < CHANNELS) begin : g_fifo
      axo_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push[c]),
        .pop   (fifo_pop[c]),
        .wdata (mem_wdata[7:0]),
        .rdata (fifo_rdata[c]),
        .full  (fifo_full[c]),
        .empty (fifo_empty[c]),
        .level (fifo_level[c])
      );
    end else begin : g_none
      assign fifo_full[c]  = 1'b0;
      assign fifo_empty[c] = 1'b1;
      assign fifo_rdata[c] = '0;
      assign fifo_level[c] = '0;
      logic unused_ctl;
      assign unused_ctl = fifo_push[c] | fifo_pop[c];
    end
  end

  // Bus decode and response.
  always_comb begin
    hit     = (mem_re || mem_we) && (mem_addr[31:5] == BASE_ADDR[31:5]);
    sel     = decode_sel(mem_addr[4:0]);
    tx_chan = mem_addr[3:2];
    tx_wr   = hit && mem_we && (sel == SEL_TX) && ({1'b0, tx_chan} < NCH) && !done_q;
    // full is registered, so a pop on this edge only lifts the stall next cycle.
    stall   = tx_wr && fifo_full[tx_chan];
    exit_wr = hit && mem_we && (sel == SEL_EXIT);

    fifo_push = '0;
    if (tx_wr && !fifo_full[tx_chan]) fifo_push[tx_chan] = 1'b1;

    mem_rdata = '0;
    if (hit && mem_re) begin
      case (sel)
        SEL_TX:     mem_rdata = 32'(fifo_level[tx_chan]);
        SEL_STATUS: begin
          mem_rdata[STAT_FULL_LSB +: MAX_CHANNELS]  = fifo_full;
          mem_rdata[STAT_EMPTY_LSB +: MAX_CHANNELS] = fifo_empty;
          mem_rdata[STAT_DONE_BIT]                  = done_q;
        end
        SEL_EXIT:   mem_rdata = {timed_out_q, 15'b0, 8'b0, exit_code_q};
        SEL_CYCLE:  mem_rdata = cycle_q;
        default:    mem_rdata = '0;
      endcase
    end
  end

  assign mem_hit   = hit;
  assign mem_ready = rst || !stall;

  // Round-robin pick: first non-empty channel after the last granted one.
  always_comb begin
    gnt_found = 1'b0;
    gnt_chan  = rr_q;
    cand      = '0;
    for (int i = 1; i <= MAX_CHANNELS; i++) begin
      if (i <= CHANNELS) begin
        cand = {1'b0, rr_q} + 3'(i);
        if (cand >= NCH) cand = cand - NCH;
        if (!gnt_found && !fifo_empty[cand[1:0]]) begin
          gnt_found = 1'b1;
          gnt_chan  = cand[1:0];
        end
      end
    end
  end

  // Output register reloads when empty or being consumed this cycle.
  always_comb begin
    load        = !out_valid_q || out_ready;
    fifo_pop    = '0;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    out_data_d  = out_data_q;
    rr_d        = rr_q;
    if (load) begin
      if (gnt_found) begin
        fifo_pop[gnt_chan] = 1'b1;
        out_valid_d        = 1'b1;
        out_chan_d         = gnt_chan;
        out_data_d         = fifo_rdata[gnt_chan];
        rr_d               = gnt_chan;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Run control: first cause of done wins; EXIT beats a same-edge timeout.
  always_comb begin
    timeout_now = (TIMEOUT != 0) && (cycle_q == TIMEOUT_LAST) && !done_q;
    cycle_d     = done_q ? cycle_q : cycle_q + 32'd1;
    done_d      = done_q;
    timed_out_d = timed_out_q;
    exit_code_d = exit_code_q;
    if (!done_q) begin
      if (exit_wr) begin
        done_d      = 1'b1;
        exit_code_d = mem_wdata[7:0];
        timed_out_d = 1'b0;
      end else if (timeout_now) begin
        done_d      = 1'b1;
        exit_code_d = EXIT_CODE_TIMEOUT;
        timed_out_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q     <= '0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      exit_code_q <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
      rr_q        <= 2'(CHANNELS - 1);
    end else begin
      cycle_q     <= cycle_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      exit_code_q <= exit_code_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_data_q  <= out_data_d;
      rr_q        <= rr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign exit_code = exit_code_q;
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_axo_sim_console.sv
// Bench for axo_sim_console (2 channels, depth 4, watchdog 120 cycles).
// A queue-based reference model advances once per clock edge and supplies
// every expected value; directed steps cover the named scenarios and a
// randomized phase mixes traffic, reads and backpressure.
module tb_axo_sim_console;
  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam int          CH    = 2;
  localparam int          DEPTH = 4;
  localparam int          TO    = 120;

  logic        clk = 1'b0;
  logic        rst, mem_re, mem_we, out_ready;
  logic [1:0]  mem_asize;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_hit, mem_ready, out_valid, done, timed_out;
  logic [1:0]  out_chan;
  logic [7:0]  out_data, exit_code;

  always #5 clk = ~clk;

  axo_sim_console #(.BASE_ADDR(BASE), .CHANNELS(CH), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we), .mem_asize(mem_asize),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_hit(mem_hit),
    .mem_ready(mem_ready), .out_valid(out_valid), .out_chan(out_chan), .out_data(out_data),
    .out_ready(out_ready), .done(done), .exit_code(exit_code), .timed_out(timed_out)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0]  mq0[$], mq1[$];
  logic        m_ov, m_done, m_to;
  int          m_oc, m_last;
  logic [7:0]  m_od, m_code;
  logic [31:0] m_cnt;
  logic [9:0]  sink[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int c);
    return (c == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic int m_off();
    return int'(mem_addr & 32'h1F);
  endfunction

  function automatic logic m_hit();
    return (mem_re || mem_we) && ((mem_addr & 32'hFFFF_FFE0) == BASE);
  endfunction

  function automatic logic m_txw();
    return m_hit() && mem_we && (m_off() < 16) && (m_off() / 4 < CH) && !m_done;
  endfunction

  function automatic logic m_ready();
    return rst || !(m_txw() && qsize(m_off() / 4) == DEPTH);
  endfunction

  function automatic logic [31:0] m_rdata();
    int off;
    off = m_off();
    if (!(m_hit() && mem_re)) return 32'h0;
    if (off < 16) return (off / 4 < CH) ? 32'(qsize(off / 4)) : 32'h0;
    if (off == 16)
      return {23'b0, m_done, 2'b11, qsize(1) == 0, qsize(0) == 0,
              2'b00, qsize(1) == DEPTH, qsize(0) == DEPTH};
    if (off == 20) return {m_to, 23'b0, m_code};
    if (off == 24) return m_cnt;
    return 32'h0;
  endfunction

  // Applies the effect of one rising edge to the model, using pre-edge state.
  task automatic model_edge();
    int sz0, sz1, c, off;
    logic load, got, txw, exitw;
    if (rst) begin
      mq0.delete(); mq1.delete();
      m_ov = 0; m_oc = 0; m_od = 0; m_last = CH - 1;
      m_done = 0; m_to = 0; m_code = 0; m_cnt = 0;
      return;
    end
    off   = m_off();
    txw   = m_txw();
    exitw = m_hit() && mem_we && (off == 20);
    sz0   = mq0.size();
    sz1   = mq1.size();
    load  = !m_ov || out_ready;
    got   = 0;
    if (load) begin
      for (int k = 1; k <= CH; k++) begin
        c = (m_last + k) % CH;
        if (!got && ((c == 0 && sz0 > 0) || (c == 1 && sz1 > 0))) begin
          got = 1;
          if (c == 0) m_od = mq0.pop_front();
          else        m_od = mq1.pop_front();
          m_oc = c; m_ov = 1; m_last = c;
        end
      end
      if (!got) m_ov = 0;
    end
    if (txw) begin
      c = off / 4;
      if (c == 0 && sz0 < DEPTH) mq0.push_back(mem_wdata[7:0]);
      if (c == 1 && sz1 < DEPTH) mq1.push_back(mem_wdata[7:0]);
    end
    if (!m_done) begin
      if (exitw) begin
        m_done = 1; m_code = mem_wdata[7:0]; m_to = 0;
      end else if (m_cnt == 32'(TO - 1)) begin
        m_done = 1; m_code = 8'hFF; m_to = 1;
      end
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("mem_hit", mem_hit, m_hit());
    chk("mem_ready", mem_ready, m_ready());
    if (mem_re && !rst) chk("mem_rdata", mem_rdata, m_rdata());
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_chan", out_chan, m_oc);
    end
    chk("done", done, m_done);
    chk("exit_code", exit_code, m_code);
    chk("timed_out", timed_out, m_to);
    if (out_valid && out_ready) sink.push_back({out_chan, out_data});
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic re_i, input logic we_i, input logic [31:0] addr_i,
                       input logic [31:0] wdata_i);
    mem_re = re_i; mem_we = we_i; mem_addr = addr_i; mem_wdata = wdata_i;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  logic [9:0] exp_rr [6];
  int         op, ch;

  initial begin
    rst = 1'b1; out_ready = 1'b0; mem_asize = 2'b10;
    idle();
    model_edge();
    @(posedge clk); #1;
    do_reset();

    // Reset state.
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_exit_code", exit_code, 0);
    chk("rst_timed_out", timed_out, 0);
    drive(1'b1, 1'b0, BASE + 32'h10, 32'h0); #1;
    chk("rst_status", mem_rdata, 32'h0000_00F0);
    drive(1'b1, 1'b0, BASE + 32'h18, 32'h0); #1;
    chk("rst_cycle", mem_rdata, 32'h0);
    tick();

    // "Hi" on channel 0 at full rate.
    out_ready = 1'b1;
    drive(1'b0, 1'b1, BASE, 32'h48); tick();
    drive(1'b0, 1'b1, BASE, 32'h69); tick();
    idle();
    chk("hi_valid0", out_valid, 1);
    chk("hi_data0", out_data, 8'h48);
    chk("hi_chan0", out_chan, 0);
    tick();
    chk("hi_valid1", out_valid, 1);
    chk("hi_data1", out_data, 8'h69);
    tick();
    chk("hi_drained", out_valid, 0);

    // Round-robin order across two channels.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1, BASE, 32'(8'hA1 + i)); tick(); end
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1, BASE + 4, 32'(8'hB1 + i)); tick(); end
    idle();
    sink.delete();
    out_ready = 1'b1;
    repeat (8) tick();
    exp_rr = '{10'h0A1, 10'h1B1, 10'h0A2, 10'h1B2, 10'h0A3, 10'h1B3};
    chk("rr_count", sink.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < sink.size()) chk($sformatf("rr_order%0d", i), sink[i], exp_rr[i]);

    // Full-FIFO stall. The output register absorbs the first byte, so five
    // writes fit (1 held + 4 queued) and the sixth stalls.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b1, BASE, 32'(8'h10 + i)); tick(); end
    drive(1'b1, 1'b0, BASE + 32'h10, 32'h0); #1;
    chk("stall_status_full", mem_rdata[0], 1);
    drive(1'b1, 1'b0, BASE, 32'h0); #1;
    chk("stall_level", mem_rdata, 4);
    drive(1'b0, 1'b1, BASE, 32'h15); #1;
    chk("stall_ready0", mem_ready, 0);
    tick();
    tick();
    out_ready = 1'b1; #1;
    chk("stall_same_cycle_pop", mem_ready, 0);
    tick();
    out_ready = 1'b0; #1;
    chk("stall_release", mem_ready, 1);
    tick();
    drive(1'b1, 1'b0, BASE + 32'h10, 32'h0); #1;
    chk("stall_full_again", mem_rdata[0], 1);
    tick();

    // Reset while stalled with bytes queued.
    drive(1'b0, 1'b1, BASE, 32'h16); #1;
    chk("pre_rst_stall", mem_ready, 0);
    rst = 1'b1; #1;
    chk("rst_ready", mem_ready, 1);
    tick();
    rst = 1'b0;
    idle();
    chk("post_rst_valid", out_valid, 0);
    drive(1'b1, 1'b0, BASE + 32'h10, 32'h0); #1;
    chk("post_rst_empty", mem_rdata[7:4], 4'hF);
    chk("post_rst_full", mem_rdata[3:0], 4'h0);
    tick();

    // Randomized traffic; runs past the watchdog so post-done drops are hit.
    do_reset();
    for (int it = 0; it < 250; it++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, 3);
      mem_asize = 2'($urandom_range(0, 3));
      case (op)
        0, 1, 2, 3, 4: drive(1'b0, 1'b1, BASE + 32'(4 * ch), $urandom);
        5:             drive(1'b1, 1'b0, BASE + 32'(4 * ch), 32'h0);
        6:             drive(1'b1, 1'b0, BASE + 32'h10, 32'h0);
        7:             drive(1'b1, 1'b0, BASE + 32'(32'h14 + 4 * (ch % 3)), 32'h0);
        8:             if ($urandom_range(0, 30) == 0) drive(1'b0, 1'b1, BASE + 32'h14, $urandom);
                       else idle();
        default:       drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                             (ch[0] ? BASE - 32'h4 : BASE + 32'h20), $urandom);
      endcase
      tick();
    end
    idle();
    mem_asize = 2'b10;

    // EXIT at cycle 100; counter freezes and a later timeout is ignored.
    do_reset();
    out_ready = 1'b1;
    repeat (100) tick();
    drive(1'b1, 1'b0, BASE + 32'h18, 32'h0); #1;
    chk("exit_cycle_before", mem_rdata, 100);
    drive(1'b0, 1'b1, BASE + 32'h14, 32'h2A); tick();
    idle();
    chk("exit_done", done, 1);
    chk("exit_code", exit_code, 8'h2A);
    chk("exit_not_to", timed_out, 0);
    drive(1'b1, 1'b0, BASE + 32'h18, 32'h0); #1;
    chk("exit_cycle_frozen", mem_rdata, 101);
    idle();
    repeat (40) tick();
    drive(1'b0, 1'b1, BASE + 32'h14, 32'h55); tick();
    chk("exit_first_wins", exit_code, 8'h2A);
    chk("exit_no_timeout", timed_out, 0);
    drive(1'b1, 1'b0, BASE + 32'h18, 32'h0); #1;
    chk("exit_cycle_still", mem_rdata, 101);
    drive(1'b1, 1'b0, BASE + 32'h14, 32'h0); #1;
    chk("exit_reg", mem_rdata, 32'h0000_002A);
    tick();

    // Watchdog fires after exactly TO cycles.
    do_reset();
    repeat (TO - 1) tick();
    chk("to_not_yet", done, 0);
    tick();
    chk("to_done", done, 1);
    chk("to_flag", timed_out, 1);
    chk("to_code", exit_code, 8'hFF);
    drive(1'b1, 1'b0, BASE + 32'h14, 32'h0); #1;
    chk("to_exit_reg", mem_rdata, 32'h8000_00FF);
    tick();

    // EXIT on the same edge as the timeout wins.
    do_reset();
    repeat (TO - 1) tick();
    drive(1'b0, 1'b1, BASE + 32'h14, 32'h07); tick();
    idle();
    chk("same_edge_done", done, 1);
    chk("same_edge_to", timed_out, 0);
    chk("same_edge_code", exit_code, 8'h07);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
